// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID and PC sequencing for the 5-stage pipe: load-use stall, taken-branch flush,
// data-memory freeze, saturating stall/redirect counters and a busy watchdog.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  input  logic             cnt_clr_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redir_cnt_o,
  output logic             err_timeout_o
);

  typedef enum logic [1:0] {StRun, StLuStall, StFlush} state_e;

  localparam logic [2:0]       FlushInit  = 3'(FLUSH_DEPTH - 1);
  localparam logic [15:0]      TimeoutVal = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [15:0]      bcnt_q, bcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic             err_q, err_d;
  logic             lu_haz;
  logic             redir_inc;

  assign lu_haz = idex_memread_i & (idex_rt_i != '0) &
                  ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    redir_inc     = 1'b0;
    if (dmem_busy_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_freeze_o = 1'b1;
    end else begin
      unique case (state_q)
        StRun, StLuStall: begin
          if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            redir_inc     = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              state_d = StFlush;
              fcnt_d  = FlushInit;
            end else begin
              state_d = StRun;
            end
          end else if (state_q == StRun && lu_haz) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            state_d       = StLuStall;
          end else begin
            state_d = StRun;
          end
        end
        StFlush: begin
          // Wrong-path branches are squashed here, so branch_taken_i is ignored.
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
          fcnt_d        = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
    if (rst_i) begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    bcnt_d      = '0;
    err_d       = err_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
      redir_cnt_d = '0;
    end else begin
      if (!pc_write_o && stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + 1'b1;
      if (redir_inc && redir_cnt_q != CntMax) redir_cnt_d = redir_cnt_q + 1'b1;
    end
    if (dmem_busy_i) begin
      bcnt_d = (bcnt_q >= TimeoutVal) ? bcnt_q : bcnt_q + 16'd1;
      // Flag on the edge where the busy run length reaches TIMEOUT.
      if (bcnt_q >= TimeoutVal - 16'd1) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      fcnt_q      <= '0;
      bcnt_q      <= '0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      bcnt_q      <= bcnt_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
      err_q       <= err_d;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign redir_cnt_o   = redir_cnt_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int FLUSH_DEPTH = 2;
  localparam int TIMEOUT = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic memread = 1'b0, uses_rt = 1'b0, br = 1'b0, busy = 1'b0, clr = 1'b0;
  logic [REG_W-1:0] idex_rt = '0, if_rs = '0, if_rt = '0;
  logic pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, err_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, redir_cnt_o;

  int n_tests = 0;
  int n_fail = 0;

  // Model state: remaining flush cycles, "just stalled" flag, busy run length, counters.
  int m_flush_left, m_busy_run, m_stall, m_redir;
  bit m_stalled, m_err;

  logic [4:0] got, exp_ctl;

  pipeline_hazard_ctrl #(
    .REG_W(REG_W), .CNT_W(CNT_W), .FLUSH_DEPTH(FLUSH_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(idex_rt),
    .ifid_rs_i(if_rs), .ifid_rt_i(if_rt), .ifid_uses_rt_i(uses_rt),
    .branch_taken_i(br), .dmem_busy_i(busy), .cnt_clr_i(clr),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .pipe_freeze_o(pipe_freeze_o),
    .stall_cnt_o(stall_cnt_o), .redir_cnt_o(redir_cnt_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  function automatic bit hazard();
    return memread && idex_rt != 0 && (idex_rt == if_rs || (uses_rt && idex_rt == if_rt));
  endfunction

  // Expected {pc_write, ifid_write, flush, bubble, freeze}.
  function automatic logic [4:0] predict();
    if (rst) return 5'b11000;
    if (busy) return 5'b00001;
    if (m_flush_left > 0 || br) return 5'b11110;
    if (hazard() && !m_stalled) return 5'b00010;
    return 5'b11000;
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_busy_run = 0; m_stall = 0; m_redir = 0;
    m_stalled = 0; m_err = 0;
  endtask

  task automatic drive(input bit mr, input int rt_x, input int rs, input int rt_y,
                       input bit ur, input bit b, input bit bz, input bit c);
    memread = mr; idex_rt = REG_W'(rt_x); if_rs = REG_W'(rs); if_rt = REG_W'(rt_y);
    uses_rt = ur; br = b; busy = bz; clr = c;
  endtask

  // Advance model and DUT by one rising edge; returns 1 ns after the edge.
  task automatic tick();
    int fl = m_flush_left, br_run = m_busy_run, st = m_stall, rd = m_redir;
    bit stl = m_stalled, er = m_err;
    if (busy) begin
      st++;
      br_run++;
      if (br_run >= TIMEOUT) er = 1;
    end else begin
      br_run = 0;
      if (fl > 0) begin
        fl--; stl = 0;
      end else if (br) begin
        rd++; fl = FLUSH_DEPTH - 1; stl = 0;
      end else if (hazard() && !stl) begin
        stl = 1; st++;
      end else begin
        stl = 0;
      end
    end
    if (st > CMAX) st = CMAX;
    if (rd > CMAX) rd = CMAX;
    if (clr) begin
      st = 0; rd = 0;
    end
    @(posedge clk);
    m_flush_left = fl; m_busy_run = br_run; m_stall = st; m_redir = rd;
    m_stalled = stl; m_err = er;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 5, 5, 0, 0, 1, 0, 0);
    model_reset();
    #2;
    got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
    n_tests++;
    if (got !== 5'b11000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 11000", got);
    end
    n_tests++;
    if (stall_cnt_o !== '0 || redir_cnt_o !== '0 || err_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: stall=%0d redir=%0d err=%b expected 0 0 0",
               stall_cnt_o, redir_cnt_o, err_timeout_o);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    #1;
    got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
    n_tests++;
    if (got !== 5'b00010) begin
      n_fail++; $display("FAIL load_use_stall: got %b expected 00010", got);
    end
    tick();
    #1;
    got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
    n_tests++;
    if (got !== 5'b11000) begin
      n_fail++; $display("FAIL load_use_release: got %b expected 11000", got);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_tests++;
    if (stall_cnt_o !== CNT_W'(1) || 32'(stall_cnt_o) !== m_stall) begin
      n_fail++; $display("FAIL load_use_count: stall_cnt=%0d expected 1", stall_cnt_o);
    end
  endtask

  task automatic test_no_stall();
    // {memread, idex_rt, rs, rt, uses_rt}: rt=0 match, rt match unused, rt match used.
    int tbl[3][5] = '{'{1, 0, 0, 0, 1}, '{1, 7, 3, 7, 0}, '{1, 7, 3, 7, 1}};
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i][0] != 0, tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4] != 0, 0, 0, 0);
      #1;
      exp_ctl = predict();
      got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
      n_tests++;
      if (got !== exp_ctl) begin
        n_fail++; $display("FAIL no_stall[%0d]: got %b expected %b", i, got, exp_ctl);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_branch_flush();
    int redir0 = m_redir;
    for (int i = 0; i < 3; i++) begin
      // Branch plus hazard for two cycles (second branch is wrong path), then quiet.
      if (i < 2) drive(1, 4, 4, 0, 0, 1, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      exp_ctl = (i < 2) ? 5'b11110 : 5'b11000;
      got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
      n_tests++;
      if (got !== exp_ctl || predict() !== exp_ctl) begin
        n_fail++; $display("FAIL branch_flush[%0d]: got %b expected %b", i, got, exp_ctl);
      end
      tick();
    end
    n_tests++;
    if (32'(redir_cnt_o) !== redir0 + 1 || m_redir !== redir0 + 1) begin
      n_fail++; $display("FAIL branch_redir: redir=%0d expected %0d", redir_cnt_o, redir0 + 1);
    end
  endtask

  task automatic test_freeze_mid_flush();
    int stall0;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    stall0 = m_stall;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, i == 4, i < 3, 0);
      #1;
      exp_ctl = predict();
      got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
      n_tests++;
      if (got !== exp_ctl) begin
        n_fail++; $display("FAIL freeze_flush[%0d]: got %b expected %b", i, got, exp_ctl);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (32'(stall_cnt_o) !== stall0 + 3) begin
      n_fail++; $display("FAIL freeze_stall_cnt: got %0d expected %0d", stall_cnt_o, stall0 + 3);
    end
    tick(); tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 0, 0, 0, i < 5, 0);
      tick();
      n_tests++;
      if (err_timeout_o !== m_err || err_timeout_o !== (i >= 3)) begin
        n_fail++; $display("FAIL timeout[%0d]: err=%b expected %b", i, err_timeout_o, i >= 3);
      end
    end
  endtask

  task automatic test_reset_mid_flush_and_clear();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
    n_tests++;
    if (got !== 5'b11000 || err_timeout_o !== 1'b0 || redir_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ctl=%b err=%b redir=%0d expected 11000 0 0",
               got, err_timeout_o, redir_cnt_o);
    end
    #3;
    rst = 1'b0;
    @(posedge clk); #2;
    got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
    n_tests++;
    if (got !== 5'b11000) begin
      n_fail++; $display("FAIL reset_to_run: got %b expected 11000", got);
    end
    drive(1, 3, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) tick();
    n_tests++;
    if (32'(stall_cnt_o) !== CMAX || m_stall !== CMAX) begin
      n_fail++; $display("FAIL stall_saturate: got %0d expected %0d", stall_cnt_o, CMAX);
    end
    clr = 1'b1;
    tick();
    n_tests++;
    if (stall_cnt_o !== '0 || m_stall !== 0) begin
      n_fail++; $display("FAIL cnt_clear: got %0d expected 0", stall_cnt_o);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(1, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0),
            $urandom_range(3, 0), $urandom_range(1, 0) != 0, $urandom_range(4, 0) == 0,
            $urandom_range(7, 0) == 0, $urandom_range(29, 0) == 0);
      #1;
      exp_ctl = predict();
      got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o};
      n_tests++;
      if (got !== exp_ctl) begin
        n_fail++; $display("FAIL random_ctrl[%0d]: got %b expected %b", i, got, exp_ctl);
      end
      tick();
      n_tests++;
      if (32'(stall_cnt_o) !== m_stall || 32'(redir_cnt_o) !== m_redir ||
          err_timeout_o !== m_err) begin
        n_fail++;
        $display("FAIL random_state[%0d]: stall=%0d redir=%0d err=%b expected %0d %0d %b",
                 i, stall_cnt_o, redir_cnt_o, err_timeout_o, m_stall, m_redir, m_err);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_flush();
    test_freeze_mid_flush();
    test_timeout();
    test_reset_mid_flush_and_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
